// File: rtl/imem_responder_pkg.sv
// ---------------------------------------------------------------------------
// rv_imem_pkg: shared types for the instruction-memory fetch interface.
//   imem_err_t    response error code (OK / misaligned / out of range)
//   imem_rsp_t    one queued response: instruction word plus error code
//   imem_classify address check used by both the fetch and program-load paths
// ---------------------------------------------------------------------------
package rv_imem_pkg;

    localparam int IMEM_WORD_BYTES = 4;
    localparam int IMEM_OFF_BITS   = $clog2(IMEM_WORD_BYTES);

    typedef enum logic [1:0] {
        IMEM_OK       = 2'b00,
        IMEM_MISALIGN = 2'b01,
        IMEM_RANGE    = 2'b10
    } imem_err_t;

    typedef struct packed {
        logic [31:0] data;
        imem_err_t   err;
    } imem_rsp_t;

    // Misalignment is checked first so it wins when the address is also
    // beyond the array. The full upper address is compared, so a large
    // address can never alias onto a low word.
    function automatic imem_err_t imem_classify(input logic [31:0] addr,
                                                input int unsigned depth_words);
        logic [31:0] idx;
        idx = addr >> IMEM_OFF_BITS;
        if (addr[IMEM_OFF_BITS-1:0] != '0)
            return IMEM_MISALIGN;
        else if (idx >= depth_words)
            return IMEM_RANGE;
        else
            return IMEM_OK;
    endfunction

endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// ---------------------------------------------------------------------------
// imem_rsp_fifo: small in-order response queue.
//   clk, reset      clock, asynchronous active-low reset (discards entries)
//   i_push/i_push_data  enqueue (ignored when full)
//   i_pop           dequeue head (ignored when empty)
//   o_head          entry at the head (undefined content when empty)
//   o_count/o_full/o_empty  occupancy, all from registered state
// DEPTH is expected to be 2 or 4.
// ---------------------------------------------------------------------------
module imem_rsp_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = rv_imem_pkg::imem_rsp_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  T                           i_push_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // Entry storage carries no reset: the count alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder: target side of the instruction fetch interface.
//   clk, reset                       clock, async active-low reset
//   req_valid/req_ready/req_addr     fetch request (byte address)
//   rsp_valid/rsp_ready/rsp_data/rsp_err  in-order response channel
//   prog_we/prog_addr/prog_data      program-load word write port
//   err_count                        saturating count of accepted error fetches
// The array is read at the accept edge straight into the response queue, so a
// fetch into an empty queue shows up one cycle later. The array is not reset.
// ---------------------------------------------------------------------------
module imem_responder
    import rv_imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic [15:0] err_count
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [15:0]   r_err_count;

    logic          w_req_fire;
    logic          w_rsp_pop;
    imem_err_t     w_req_err;
    logic [AW-1:0] w_req_idx;
    logic [AW-1:0] w_prog_idx;
    logic          w_prog_ok;
    imem_rsp_t     w_push_rsp;
    imem_rsp_t     w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;

    // ---------------- request side ----------------
    assign req_ready  = !w_full;
    assign w_req_fire = req_valid && req_ready;
    assign w_req_err  = imem_classify(req_addr, DEPTH_WORDS);
    assign w_req_idx  = req_addr[IMEM_OFF_BITS +: AW];

    // Index bits are only trusted once the range check has passed.
    always_comb begin
        w_push_rsp      = '0;
        w_push_rsp.err  = w_req_err;
        w_push_rsp.data = (w_req_err == IMEM_OK) ? r_mem[w_req_idx] : 32'h0;
    end

    // ---------------- program-load port ----------------
    assign w_prog_ok  = (imem_classify(prog_addr, DEPTH_WORDS) == IMEM_OK);
    assign w_prog_idx = prog_addr[IMEM_OFF_BITS +: AW];

    // Non-blocking write alongside the fetch read gives read-first behaviour
    // when both hit the same word on one edge.
    always_ff @(posedge clk) begin
        if (prog_we && w_prog_ok)
            r_mem[w_prog_idx] <= prog_data;
    end

    // ---------------- response queue ----------------
    imem_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (imem_rsp_t)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_req_fire),
        .i_push_data (w_push_rsp),
        .i_pop       (w_rsp_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign rsp_valid = (w_count != '0);
    assign w_rsp_pop = rsp_valid && rsp_ready;
    assign rsp_data  = w_empty ? 32'h0 : w_head.data;
    assign rsp_err   = w_empty ? IMEM_OK : w_head.err;

    // ---------------- error counter ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_err_count <= '0;
        else if (w_req_fire && (w_req_err != IMEM_OK) && (r_err_count != 16'hFFFF))
            r_err_count <= r_err_count + 16'd1;
    end

    assign err_count = r_err_count;

endmodule
